load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, word-address width of the attached data RAM port.
REQ-002 SHALL have one clock, clk; reset is rst_n, asynchronous, active-low.
REQ-003 clk  in  1  rising-edge clock, shared with data RAM.
REQ-004 rst_n  in  1  async active-low reset.
REQ-005 req_valid  in  1  core access request.
REQ-006 req_ready  out  1  unit idle, request accepted when req_valid&&req_ready.
REQ-007 req_we  in  1  1=store, 0=load.
REQ-008 req_funct3  in  3  RV32I width/sign code.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, LSB-aligned.
REQ-011 rsp_valid  out  1  one-cycle completion pulse; core always accepts.
REQ-012 rsp_rdata  out  32  load result, extended; 0 for stores/errors.
REQ-013 rsp_err  out  1  access rejected, valid with rsp_valid.
REQ-014 mem_we  out  1  RAM write enable.
REQ-015 mem_wmask  out  4  RAM byte-lane mask.
REQ-016 mem_addr  out  ADDR_WIDTH  RAM word address = req_addr[ADDR_WIDTH+1:2]; upper bits ignored.
REQ-017 mem_wdata  out  32  lane-replicated store data.
REQ-018 mem_rdata  in  32  RAM read data, registered by RAM, valid one cycle after mem_addr sampled.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; req_ready=1 only in IDLE.
REQ-020 Accept in IDLE: legal access -> ISSUE; error -> RESP (error latched).
REQ-021 ISSUE: mem_addr/mem_we/mem_wmask/mem_wdata registered and stable; store -> RESP; load -> WAIT.
REQ-022 WAIT: extracted load data latched into rsp_rdata at end of cycle; -> RESP.
REQ-023 RESP: rsp_valid=1 exactly one cycle; -> IDLE.
REQ-024 Latency accept-to-rsp_valid SHALL be: load 3 cycles, store 2, error 1... counted as cycles after the accept edge (load cycle 3, store cycle 2, error cycle 1).
REQ-025 Loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; byte lane addr[1:0], half lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-026 Stores: 000 SB wmask=1<<addr[1:0], wdata={4{byte}}; 001 SH wmask 0011 (addr[1]=0) / 1100, wdata={2{half}}; 010 SW wmask 1111.
REQ-027 Illegal funct3 (loads 011,110,111; stores 011-111) SHALL give rsp_err=1, rsp_rdata=0, no mem_we.
REQ-028 mem_we and mem_wmask SHALL be 0 in every state except ISSUE of a store.
REQ-029 req inputs ignored outside IDLE; no back-to-back acceptance during RESP.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_wmask=0, mem_addr=0, mem_wdata=0; req_ready=1 while in IDLE.
REQ-031 Reset mid-access SHALL abort it with no rsp_valid and no further write; next request accepted on first edge after release.

Configuration
REQ-032 Macro LSU_MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, SHALL take error path (rsp_err=1, no RAM access).
REQ-033 Macro undefined: misaligned offsets SHALL be silently truncated (halfword ignores addr[0], word ignores addr[1:0]); rsp_err only for illegal funct3.

Verification
REQ-034 SW addr 0x10 wdata 0xDEADBEEF -> cycle 1 mem_we=1, wmask=1111, mem_addr=4, mem_wdata=0xDEADBEEF; cycle 2 rsp_valid=1, rsp_err=0.
REQ-035 LB addr 0x13, mem_rdata 0x80FF0102 -> cycle 3 rsp_rdata=0xFFFFFF80; LBU same -> 0x00000080.
REQ-036 SH addr 0x06 wdata 0x1234ABCD -> mem_addr=1, wmask=1100, mem_wdata=0xABCDABCD.
REQ-037 LH addr 0x01: macro on -> cycle 1 rsp_valid, rsp_err=1, rsp_rdata=0, mem_we never 1; macro off, mem_rdata 0x0000F00D -> rsp_rdata=0xFFFFF00D.
REQ-038 funct3=011 load -> rsp_err=1 at cycle 1, no RAM write.
REQ-039 rst_n low during WAIT -> all outputs 0 at once, no rsp_valid; after release LW addr 0 completes normally at cycle 3.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store unit driving a single-port registered-read data RAM.
// Optional misalignment trapping is enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_we,
  output logic [3:0]            mem_wmask,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]            state_r;
  logic [2:0]            f3_r;
  logic [1:0]            off_r;
  logic                  rsp_valid_r;
  logic [31:0]           rsp_rdata_r;
  logic                  rsp_err_r;
  logic                  mem_we_r;
  logic [3:0]            mem_wmask_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [31:0]           mem_wdata_r;

  logic                  funct3_ok_s;
  logic                  misalign_s;
  logic                  legal_s;
  logic [3:0]            st_mask_s;
  logic [31:0]           st_data_s;
  logic                  unused_addr_s;

  // Select the addressed lane and sign/zero-extend it; halfword uses addr[1] only.
  function automatic logic [31:0] load_extract_f(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] word);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res_v;
    byte_v = word[{off, 3'b000} +: 8];
    half_v = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  res_v = {{24{byte_v[7]}}, byte_v};
      3'b001:  res_v = {{16{half_v[15]}}, half_v};
      3'b010:  res_v = word;
      3'b100:  res_v = {24'h000000, byte_v};
      3'b101:  res_v = {16'h0000, half_v};
      default: res_v = 32'h0000_0000;
    endcase
    return res_v;
  endfunction

  assign unused_addr_s = ^req_addr[31:ADDR_WIDTH+2];

  // Legality of the incoming funct3 for its direction.
  always_comb begin
    funct3_ok_s = 1'b0;
    if (req_we) begin
      funct3_ok_s = (req_funct3 <= 3'b010);
    end else begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: funct3_ok_s = 1'b1;
        default:                                funct3_ok_s = 1'b0;
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_s = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
`else
  assign misalign_s = 1'b0;
`endif

  assign legal_s = funct3_ok_s && !misalign_s;

  // Byte-lane mask and lane-replicated data for stores.
  always_comb begin
    st_mask_s = 4'b0000;
    st_data_s = 32'h0000_0000;
    case (req_funct3)
      3'b000: begin
        st_mask_s = 4'b0001 << req_addr[1:0];
        st_data_s = {4{req_wdata[7:0]}};
      end
      3'b001: begin
        st_mask_s = req_addr[1] ? 4'b1100 : 4'b0011;
        st_data_s = {2{req_wdata[15:0]}};
      end
      3'b010: begin
        st_mask_s = 4'b1111;
        st_data_s = req_wdata;
      end
      default: begin
        st_mask_s = 4'b0000;
        st_data_s = 32'h0000_0000;
      end
    endcase
  end

  // Access sequencer; errors skip the RAM and respond on the cycle after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      f3_r        <= 3'b000;
      off_r       <= 2'b00;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_wmask_r <= 4'b0000;
      mem_addr_r  <= {ADDR_WIDTH{1'b0}};
      mem_wdata_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            f3_r  <= req_funct3;
            off_r <= req_addr[1:0];
            if (legal_s) begin
              state_r     <= ISSUE;
              rsp_err_r   <= 1'b0;
              mem_addr_r  <= req_addr[ADDR_WIDTH+1:2];
              mem_wdata_r <= st_data_s;
              mem_we_r    <= req_we;
              mem_wmask_r <= req_we ? st_mask_s : 4'b0000;
            end else begin
              state_r     <= RESP;
              rsp_err_r   <= 1'b1;
              rsp_valid_r <= 1'b1;
            end
          end
        end
        ISSUE: begin
          mem_we_r    <= 1'b0;
          mem_wmask_r <= 4'b0000;
          if (mem_we_r) begin
            state_r     <= RESP;
            rsp_valid_r <= 1'b1;
          end else begin
            state_r <= WAIT;
          end
        end
        WAIT: begin
          rsp_rdata_r <= load_extract_f(f3_r, off_r, mem_rdata);
          rsp_valid_r <= 1'b1;
          state_r     <= RESP;
        end
        RESP: begin
          rsp_valid_r <= 1'b0;
          rsp_err_r   <= 1'b0;
          rsp_rdata_r <= 32'h0000_0000;
          state_r     <= IDLE;
        end
        default: begin
          state_r     <= IDLE;
          rsp_valid_r <= 1'b0;
          mem_we_r    <= 1'b0;
          mem_wmask_r <= 4'b0000;
        end
      endcase
    end
  end

  assign req_ready = (state_r == IDLE);
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;
  assign mem_we    = mem_we_r;
  assign mem_wmask = mem_wmask_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: reference model queues expected
// responses/writes at accept; a negedge monitor pops and compares.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [3:0]  mem_wmask;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        poke_en;
  logic [11:0] poke_idx;
  logic [31:0] poke_val;

  logic [31:0] ram     [0:4095];
  logic [31:0] ref_mem [0:4095];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic [11:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    int          cyc;
  } wr_t;

  rsp_t rsp_q[$];
  wr_t  wr_q[$];

  load_store_unit #(.ADDR_WIDTH(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Data RAM: registered read, byte-masked write, plus a bench preload port.
  always @(posedge clk) begin
    if (poke_en) begin
      ram[poke_idx] <= poke_val;
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic model_legal(logic we, logic [2:0] f3, logic [31:0] a);
    logic ok;
    logic mis;
    if (we) ok = (f3 <= 3'd2);
    else    ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis = ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) || (f3 == 3'd2 && a % 4 != 0);
    return ok && !(TRAP && mis);
  endfunction

  function automatic logic [31:0] model_load(logic [2:0] f3, logic [31:0] a, logic [31:0] w);
    logic [31:0] v;
    case (f3)
      3'd0, 3'd4: begin
        v = (w >> (8 * (a % 4))) & 32'd255;
        if (f3 == 3'd0 && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end
      3'd1, 3'd5: begin
        v = (w >> (16 * ((a / 2) % 2))) & 32'd65535;
        if (f3 == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  // Present one request (waiting, bounded, for ready) and queue its expectations.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
    int budget = 0;
    rsp_t r;
    wr_t  w;
    logic [11:0] idx;
    while (!req_ready && budget < 20) begin
      req_valid  = 1'($urandom);
      req_we     = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      @(negedge clk);
      budget++;
    end
    if (!req_ready) begin
      chk("accept_timeout", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b0;
      return;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    idx = 12'((a / 4) % 4096);
    if (!model_legal(we, f3, a)) begin
      r.rdata = 32'd0; r.err = 1'b1; r.cyc = cyc + 1;
    end else if (we) begin
      case (f3)
        3'd0:    begin w.mask = 4'(1 << (a % 4));                    w.wdata = wd[7:0] * 32'h0101_0101; end
        3'd1:    begin w.mask = ((a / 2) % 2 == 1) ? 4'd12 : 4'd3;   w.wdata = wd[15:0] * 32'h0001_0001; end
        default: begin w.mask = 4'd15;                               w.wdata = wd; end
      endcase
      w.addr = idx; w.cyc = cyc + 1;
      wr_q.push_back(w);
      for (int b = 0; b < 4; b++)
        if (w.mask[b]) ref_mem[idx][8*b +: 8] = w.wdata[8*b +: 8];
      r.rdata = 32'd0; r.err = 1'b0; r.cyc = cyc + 2;
    end else begin
      r.rdata = model_load(f3, a, ref_mem[idx]); r.err = 1'b0; r.cyc = cyc + 3;
    end
    rsp_q.push_back(r);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Monitor: compare every response and RAM write against the queued expectations.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          rsp_t e;
          e = rsp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
          chk("rsp_cycle", cyc, e.cyc);
        end
      end
      if (mem_we) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_write", 32'd1, 32'd0);
        end else begin
          wr_t e;
          e = wr_q.pop_front();
          chk("mem_addr", {20'd0, mem_addr}, {20'd0, e.addr});
          chk("mem_wmask", {28'd0, mem_wmask}, {28'd0, e.mask});
          chk("mem_wdata", mem_wdata, e.wdata);
          chk("write_cycle", cyc, e.cyc);
        end
      end else begin
        chk("idle_wmask", {28'd0, mem_wmask}, 32'd0);
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_wmask"}, {28'd0, mem_wmask}, 32'd0);
    chk({tag, "_mem_addr"}, {20'd0, mem_addr}, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    int budget;
    logic [31:0] v;
    logic [31:0] a;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    poke_en = 1'b0; poke_idx = 12'd0; poke_val = 32'd0;
    #1;
    chk_reset_outputs("reset");

    for (int i = 0; i < 4096; i++) begin
      @(negedge clk);
      if (i == 0)      v = 32'h0000_F00D;
      else if (i == 4) v = 32'h80FF_0102;
      else             v = $urandom;
      poke_en = 1'b1; poke_idx = 12'(i); poke_val = v;
      ref_mem[i] = v;
    end
    @(negedge clk);
    poke_en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    do_req(1'b0, 3'b000, 32'h0000_0013, 32'd0);      // LB  -> FFFFFF80
    do_req(1'b0, 3'b100, 32'h0000_0013, 32'd0);      // LBU -> 00000080
    do_req(1'b0, 3'b001, 32'h0000_0001, 32'd0);      // LH misaligned
    do_req(1'b0, 3'b011, 32'h0000_0020, 32'd0);      // illegal load funct3
    do_req(1'b1, 3'b101, 32'h0000_0024, 32'h5555_5555); // illegal store funct3
    do_req(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF);
    do_req(1'b1, 3'b001, 32'h0000_0006, 32'h1234_ABCD);
    do_req(1'b0, 3'b010, 32'h0000_0010, 32'd0);
    do_req(1'b0, 3'b101, 32'hFFFF_0006, 32'd0);      // upper address bits ignored

    // Abort a load in WAIT with reset, then restart immediately after release.
    do_req(1'b0, 3'b010, 32'h0000_0000, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    rsp_q.delete();
    wr_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b0, 3'b010, 32'h0000_0000, 32'd0);

    for (int n = 0; n < 400; n++) begin
      a = $urandom;
      if (n % 2 == 0) a = a & 32'h0000_00FF;
      do_req(1'($urandom), 3'($urandom), a, $urandom);
    end

    req_valid = 1'b0;
    budget = 0;
    while ((rsp_q.size() != 0 || wr_q.size() != 0) && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    chk("drain_rsp_q", rsp_q.size(), 32'd0);
    chk("drain_wr_q", wr_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
